instr_sequencer: RTL

//  Multi-cycle execute controller that sits directly upstream of the 8x16 register file.

---
 rtl/instr_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle execute controller driving an 8x16 register file: operand reads, shift,
// ALU and write-back for one instruction per start handshake, with CMP status flags.
module instr_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] instr,
  input  logic [W-1:0] rf_data_out,
  output logic [W-1:0] rf_data_in,
  output logic [2:0]   rf_writenum,
  output logic [2:0]   rf_readnum,
  output logic         rf_write,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         z_flag,
  output logic         n_flag,
  output logic         v_flag
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_READ_A, S_READ_B, S_EXEC, S_WRITE, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [W-1:0]          ir_q, ir_d;
  logic signed [W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic                  z_q, z_d, n_q, n_d, v_q, v_d;

  function automatic logic signed [W-1:0] shift_b(input logic signed [W-1:0] v,
                                                   input logic [1:0] s);
    case (s)
      2'b01:   return v <<< 1;
      2'b10:   return $signed($unsigned(v) >> 1);
      2'b11:   return v >>> 1;
      default: return v;
    endcase
  endfunction

  function automatic logic signed [W-1:0] sign_ext8(input logic [7:0] v);
    return $signed({{(W-8){v[7]}}, v});
  endfunction

  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_movimm, is_movreg, is_alu, is_cmp, is_mvn, illegal;
  logic signed [W-1:0] bsh, diff;

  assign opc       = ir_q[15:13];
  assign op        = ir_q[12:11];
  assign rn        = ir_q[10:8];
  assign rd        = ir_q[7:5];
  assign sh        = ir_q[4:3];
  assign rm        = ir_q[2:0];
  assign is_movimm = (opc == 3'b110) && (op == 2'b10);
  assign is_movreg = (opc == 3'b110) && (op == 2'b00);
  assign is_alu    = (opc == 3'b101);
  assign is_cmp    = is_alu && (op == 2'b01);
  assign is_mvn    = is_alu && (op == 2'b11);
  assign illegal   = !(is_movimm || is_movreg || is_alu);

  assign bsh  = shift_b(b_q, sh);
  assign diff = a_q - bsh;

  assign z_flag = z_q;
  assign n_flag = n_q;
  assign v_flag = v_q;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    z_d         = z_q;
    n_d         = n_q;
    v_d         = v_q;
    rf_data_in  = '0;
    rf_writenum = 3'd0;
    rf_readnum  = 3'd0;
    rf_write    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    case (state_q)
      S_WAIT: begin
        busy = 1'b0;
        if (start) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_movimm) begin
          c_d     = sign_ext8(ir_q[7:0]);
          state_d = S_WRITE;
        end else if (illegal) begin
          state_d = S_DONE;
        end else if (is_movreg || is_mvn) begin
          state_d = S_READ_B;
        end else begin
          state_d = S_READ_A;
        end
      end
      S_READ_A: begin
        rf_readnum = rn;
        a_d        = $signed(rf_data_out);
        state_d    = S_READ_B;
      end
      S_READ_B: begin
        rf_readnum = rm;
        b_d        = $signed(rf_data_out);
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        if (is_movreg) begin
          c_d = bsh;
        end else begin
          case (op)
            2'b00:   c_d = a_q + bsh;
            2'b01:   c_d = diff;
            2'b10:   c_d = a_q & bsh;
            default: c_d = ~bsh;
          endcase
        end
        // Flags move only on CMP; the overflow term is the classic subtract rule.
        if (is_cmp) begin
          z_d = (diff == '0);
          n_d = diff[W-1];
          v_d = (a_q[W-1] != bsh[W-1]) && (diff[W-1] != a_q[W-1]);
        end
        state_d = is_cmp ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        rf_write    = 1'b1;
        rf_writenum = is_movimm ? rn : rd;
        rf_data_in  = c_q;
        state_d     = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        err     = illegal;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

endmodule
